// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence blocks: the FSM state encoding
// and counter sizing helpers.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } seq_state_t;

   // Gap counter must exist even when no gap cycles are inserted.
   function automatic int gap_cnt_width(input int gap_cyc);
      int w;
      w = $clog2(gap_cyc + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/seq_gen.sv
// Serial pattern generator: sends a latched PAT_W-bit pattern MSB-first,
// repeat_n times, with optional idle gap cycles between repetitions.
module seq_gen
   import seq_pkg::*;
#(
   parameter int PAT_W   = 4,
   parameter int CNT_W   = 4,
   parameter int GAP_CYC = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_n,
   output logic             out,
   output logic             out_valid,
   output logic             busy,
   output logic             done
);

   localparam int BW = $clog2(PAT_W);
   localparam int GW = gap_cnt_width(GAP_CYC);
   localparam logic [BW-1:0] BIT_LAST = BW'(PAT_W - 1);
   localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

   seq_state_t       state_reg, state_next;
   logic [PAT_W-1:0] shift_reg, shift_next;
   logic [PAT_W-1:0] pat_reg, pat_next;
   logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
   logic [CNT_W-1:0] rep_cnt_reg, rep_cnt_next;
   logic [GW-1:0]    gap_cnt_reg, gap_cnt_next;
   logic             out_reg, out_next;
   logic             out_valid_reg, out_valid_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         shift_reg     <= '0;
         pat_reg       <= '0;
         bit_cnt_reg   <= '0;
         rep_cnt_reg   <= '0;
         gap_cnt_reg   <= '0;
         out_reg       <= 1'b0;
         out_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         shift_reg     <= shift_next;
         pat_reg       <= pat_next;
         bit_cnt_reg   <= bit_cnt_next;
         rep_cnt_reg   <= rep_cnt_next;
         gap_cnt_reg   <= gap_cnt_next;
         out_reg       <= out_next;
         out_valid_reg <= out_valid_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
      end
   end

   // Outputs are computed for the coming cycle, so the registers always
   // describe the bit currently on the line; shift_reg MSB is that bit.
   always_comb begin
      state_next     = state_reg;
      shift_next     = shift_reg;
      pat_next       = pat_reg;
      bit_cnt_next   = bit_cnt_reg;
      rep_cnt_next   = rep_cnt_reg;
      gap_cnt_next   = gap_cnt_reg;
      out_next       = 1'b0;
      out_valid_next = 1'b0;
      busy_next      = 1'b0;
      done_next      = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               shift_next   = pattern;
               pat_next     = pattern;
               rep_cnt_next = repeat_n;
               bit_cnt_next = BIT_LAST;
               if (repeat_n == '0) begin
                  done_next = 1'b1;
               end else begin
                  state_next     = SHIFT;
                  out_next       = pattern[PAT_W-1];
                  out_valid_next = 1'b1;
                  busy_next      = 1'b1;
               end
            end
         end

         SHIFT: begin
            if (bit_cnt_reg != '0) begin
               shift_next     = shift_reg << 1;
               bit_cnt_next   = bit_cnt_reg - 1'b1;
               out_next       = shift_reg[PAT_W-2];
               out_valid_next = 1'b1;
               busy_next      = 1'b1;
            end else begin
               shift_next   = pat_reg;
               bit_cnt_next = BIT_LAST;
               rep_cnt_next = rep_cnt_reg - 1'b1;
               // Testing for one before decrementing keeps the max count exact.
               if (rep_cnt_reg == CNT_W'(1)) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else if (GAP_CYC > 0) begin
                  state_next   = GAP;
                  gap_cnt_next = GAP_LOAD;
                  busy_next    = 1'b1;
               end else begin
                  out_next       = pat_reg[PAT_W-1];
                  out_valid_next = 1'b1;
                  busy_next      = 1'b1;
               end
            end
         end

         GAP: begin
            busy_next = 1'b1;
            if (gap_cnt_reg == '0) begin
               state_next     = SHIFT;
               out_next       = shift_reg[PAT_W-1];
               out_valid_next = 1'b1;
            end else begin
               gap_cnt_next = gap_cnt_reg - 1'b1;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign out       = out_reg;
   assign out_valid = out_valid_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;

endmodule

// File: tb/tb_seq_gen.sv
// Drives two generators (no gap and a two-cycle gap) with shared stimulus and
// compares every cycle against a queue-based model of the expected line.
module tb_seq_gen;

   localparam int PAT_W = 4;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [PAT_W-1:0] pattern = '0;
   logic [CNT_W-1:0] repeat_n = '0;

   logic out_g0, valid_g0, busy_g0, done_g0;
   logic out_g2, valid_g2, busy_g2, done_g2;

   int checks_done = 0;
   int fail_count  = 0;
   bit checking    = 1'b0;

   always #5 clk = ~clk;

   seq_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_CYC(0)) u_gen_g0 (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern), .repeat_n(repeat_n),
      .out(out_g0), .out_valid(valid_g0), .busy(busy_g0), .done(done_g0)
   );

   seq_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_CYC(2)) u_gen_g2 (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern), .repeat_n(repeat_n),
      .out(out_g2), .out_valid(valid_g2), .busy(busy_g2), .done(done_g2)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_done++;
      if (got !== exp) begin
         fail_count++;
         $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got[3:0], exp[3:0]);
      end
   endtask

   // Expected cycle records, {done, busy, out_valid, out}.
   logic [3:0] q_g0[$];
   logic [3:0] q_g2[$];
   logic [3:0] tmp_q[$];
   logic [3:0] cur_g0 = '0;
   logic [3:0] cur_g2 = '0;

   function automatic void build_stream(input int gap, input logic [PAT_W-1:0] pat,
                                        input int n);
      tmp_q.delete();
      for (int r = 0; r < n; r++) begin
         for (int i = PAT_W - 1; i >= 0; i--)
            tmp_q.push_back({2'b01, 1'b1, pat[i]});
         if (r < n - 1)
            for (int g = 0; g < gap; g++)
               tmp_q.push_back(4'b0100);
      end
      tmp_q.push_back(4'b1000);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         q_g0.delete();
         q_g2.delete();
         cur_g0 = '0;
         cur_g2 = '0;
      end else begin
         if (!cur_g0[2] && start) begin
            build_stream(0, pattern, int'(repeat_n));
            q_g0 = tmp_q;
            $display("t=%0t gen_g0 start pattern=%b repeat_n=%0d", $time, pattern, repeat_n);
         end
         cur_g0 = (q_g0.size() > 0) ? q_g0.pop_front() : 4'b0000;
         if (!cur_g2[2] && start) begin
            build_stream(2, pattern, int'(repeat_n));
            q_g2 = tmp_q;
            $display("t=%0t gen_g2 start pattern=%b repeat_n=%0d", $time, pattern, repeat_n);
         end
         cur_g2 = (q_g2.size() > 0) ? q_g2.pop_front() : 4'b0000;
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         check_eq("gen_g0", {28'd0, done_g0, busy_g0, valid_g0, out_g0}, {28'd0, cur_g0});
         check_eq("gen_g2", {28'd0, done_g2, busy_g2, valid_g2, out_g2}, {28'd0, cur_g2});
      end
   end

   task automatic idle(input int cycles);
      repeat (cycles) @(negedge clk);
   endtask

   task automatic send(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] n);
      start    = 1'b1;
      pattern  = pat;
      repeat_n = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      idle(3);
      checking = 1'b1;
      rst = 1'b0;
      idle(2);

      send(4'b1011, 4'd1);  idle(8);
      send(4'b1011, 4'd3);  idle(20);
      send(4'b1100, 4'd2);  idle(14);
      send(4'b0110, 4'd0);  idle(4);

      // Start held high: restart from the done cycle, pattern churn ignored.
      start    = 1'b1;
      repeat_n = 4'd1;
      repeat (30) begin
         pattern = PAT_W'($urandom);
         @(negedge clk);
      end
      start = 1'b0;
      idle(8);

      // Reset during the third bit, with a start coincident with reset.
      send(4'b1011, 4'd2);
      idle(2);
      rst   = 1'b1;
      start = 1'b1;
      idle(1);
      rst   = 1'b0;
      start = 1'b0;
      idle(4);
      send(4'b1011, 4'd2);  idle(16);

      send(4'b1010, 4'd15); idle(100);

      repeat (400) begin
         start    = ($urandom_range(0, 3) == 0);
         pattern  = PAT_W'($urandom);
         repeat_n = ($urandom_range(0, 7) == 0) ? 4'd15 : CNT_W'($urandom_range(0, 3));
         rst      = ($urandom_range(0, 59) == 0);
         @(negedge clk);
      end
      rst   = 1'b0;
      start = 1'b0;
      idle(100);

      checking = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", checks_done, fail_count);
      $finish;
   end

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial pattern generator: captures a PAT_W-bit pattern and a repeat count on a start request, then drives the pattern MSB-first onto a one-bit serial line, one bit per clock, for the requested number of repetitions. It is the source end of the serial bit-stream that the sequence detectors consume, used both as a stimulus driver in system tests and as a framing/preamble emitter in the datapath.

## Interface
- PAT_W, 4, pattern width in bits (≥2)
- CNT_W, 4, width of repeat count
- GAP_CYC, 0, idle cycles inserted between repetitions (0 = back-to-back)
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- pattern  input  PAT_W  pattern to send, bit PAT_W-1 sent first
- repeat_n  input  CNT_W  number of repetitions (0 allowed)
- out  output  1  serial data bit
- out_valid  output  1  high in every cycle that carries a pattern bit
- busy  output  1  high from the cycle after start acceptance through the last bit/gap cycle
- done  output  1  single-cycle pulse after the final bit

## Operation
- States: IDLE, SHIFT, GAP. All outputs registered.
- Reset: state IDLE; out=0, out_valid=0, busy=0, done=0; shift register and counters cleared.
- IDLE: on start=1 latch pattern into shift register, repeat_n into rep counter, bit counter = PAT_W-1.
  - repeat_n=0: stay IDLE, pulse done next cycle, no out_valid.
  - else go SHIFT.
- SHIFT: out = shift_reg MSB, out_valid=1, busy=1; shift left each cycle, bit counter decrements.
  - Last bit of a repetition: reload shift register from latched pattern copy, decrement rep counter.
  - More repetitions and GAP_CYC>0 → GAP; more and GAP_CYC=0 → stay SHIFT (seamless); none left → IDLE with done=1.
- GAP: out=0, out_valid=0, busy=1 for exactly GAP_CYC cycles, then SHIFT.
- start ignored outside IDLE; pattern/repeat_n changes after acceptance have no effect.
- Counter widths: bit counter $clog2(PAT_W); gap counter $clog2(GAP_CYC+1), minimum 1 bit.

## Timing
- start accepted at edge k → first bit on out in cycle k+1.
- Bit i (0 = MSB) of repetition r (0-based) at cycle k+1+r·(PAT_W+GAP_CYC)+i.
- Total busy cycles = repeat_n·PAT_W + (repeat_n−1)·GAP_CYC.
- done high exactly one cycle, the cycle after the final bit; busy and out_valid low in that cycle; out=0.
- In the done cycle the FSM is IDLE, so a start sampled then is accepted (next stream starts one cycle later, one idle cycle between streams).
- rst mid-stream: at the next edge all outputs 0, state IDLE, no done pulse; a start coincident with rst is dropped.
- repeat_n at max (2^CNT_W−1) must not wrap: exactly that many repetitions.

## Structure
- Shared package seq_pkg: state enum (IDLE, SHIFT, GAP), shared with the detector blocks' encodings.
- Single module; no sub-module needed (shift register, bit/rep/gap counters, FSM in one file).

## Test plan
- PAT_W=4, pattern=4'b1011, repeat_n=1, start at edge k → out 1,0,1,1 with out_valid in k+1..k+4; done at k+5 only.
- pattern=4'b1011, repeat_n=3, GAP_CYC=0 → 12 contiguous valid bits 101110111011; busy 12 cycles; single done.
- GAP_CYC=2, pattern=4'b1100, repeat_n=2 → 1100, two cycles out_valid=0/out=0, 1100; done after last bit.
- repeat_n=0 → no out_valid ever; done pulse at k+1; busy stays 0.
- start held high continuously with repeat_n=1 → second stream starts at done cycle+1; start pulses during busy and pattern changes mid-stream have no effect.
- rst asserted at third bit of a repeat_n=2 stream → next cycle all outputs 0, no done; new start then produces a clean full stream.
